// File: rtl/axi_cmd_sequencer.sv
// axi_cmd_sequencer: queues AXI read/write commands and issues them one at a time to a user-side AXI master.
// Optional watchdog: define AXI_SEQ_TIMEOUT_EN to abort WR_ACT/RD_ACT after TIMEOUT cycles.
// Ports: clk, resetn (async active-low, release synchronised internally)
//        cmd_valid/cmd_ready + cmd_wr/addr/len/burst/data/strb : command push
//        wr, wr_addr, wr_burst_len, wr_burst_type, wr_din, wr_strbin : write controls
//        rd_addr, rd_burst_len, rd_burst_type : read controls
//        b_done/bresp : write completion; r_beat/r_last/rdata/rresp : read beats
//        busy, cmd_done, done_resp, rd_xor, err_cnt : status
module axi_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [31:0] cmd_addr,
    input  logic [7:0]  cmd_len,
    input  logic [1:0]  cmd_burst,
    input  logic [31:0] cmd_data,
    input  logic [3:0]  cmd_strb,
    output logic        wr,
    output logic [31:0] wr_addr,
    output logic [7:0]  wr_burst_len,
    output logic [1:0]  wr_burst_type,
    output logic [31:0] wr_din,
    output logic [3:0]  wr_strbin,
    output logic [31:0] rd_addr,
    output logic [7:0]  rd_burst_len,
    output logic [1:0]  rd_burst_type,
    input  logic        b_done,
    input  logic [1:0]  bresp,
    input  logic        r_beat,
    input  logic        r_last,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    output logic        busy,
    output logic        cmd_done,
    output logic [1:0]  done_resp,
    output logic [31:0] rd_xor,
    output logic [7:0]  err_cnt
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic [31:0] data;
        logic [3:0]  strb;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, WR_ACT, RD_ACT, RESP} state_t;

    cmd_t          mem_q [DEPTH];
    cmd_t          cmd_in, head;
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic [1:0]    sync_q;
    state_t        state_q;
    logic          push, pop, wd_hit;
    logic          wr_q, busy_q, done_q;
    logic [1:0]    resp_q;
    logic [31:0]   xor_q;
    logic [7:0]    err_q;
    logic [8:0]    beat_q;
    logic [31:0]   wr_addr_q, wr_din_q, rd_addr_q;
    logic [7:0]    wr_len_q, rd_len_q;
    logic [1:0]    wr_burst_q, rd_burst_q;
    logic [3:0]    wr_strb_q;

    assign cmd_in    = {cmd_wr, cmd_addr, cmd_len, cmd_burst, cmd_data, cmd_strb};
    assign head      = mem_q[rptr_q];
    assign cmd_ready = cnt_q != (AW+1)'(DEPTH);
    assign push      = cmd_valid && cmd_ready;
    // Pops wait for the synchronised reset release (sync_q[1]).
    assign pop       = state_q == IDLE && cnt_q != '0 && sync_q[1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) sync_q <= '0;
        else         sync_q <= {sync_q[0], 1'b1};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= cmd_in;
    end

`ifdef AXI_SEQ_TIMEOUT_EN
    logic [15:0] wd_q;

    // Counts active cycles; fires once TIMEOUT cycles have elapsed, so RESP follows TIMEOUT+1 cycles after entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) wd_q <= '0;
        else         wd_q <= (state_q == WR_ACT || state_q == RD_ACT) ? wd_q + 16'd1 : '0;
    end

    assign wd_hit = wd_q == 16'(TIMEOUT);
`else
    // Watchdog compiled out: this term is constant false.
    assign wd_hit = TIMEOUT < 0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            wr_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            resp_q     <= '0;
            xor_q      <= '0;
            err_q      <= '0;
            beat_q     <= '0;
            wr_addr_q  <= '0;
            wr_len_q   <= '0;
            wr_burst_q <= '0;
            wr_din_q   <= '0;
            wr_strb_q  <= '0;
            rd_addr_q  <= '0;
            rd_len_q   <= '0;
            rd_burst_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        busy_q <= 1'b1;
                        if (head.wr) begin
                            state_q    <= WR_ACT;
                            wr_q       <= 1'b1;
                            wr_addr_q  <= head.addr;
                            wr_len_q   <= head.len;
                            wr_burst_q <= head.burst;
                            wr_din_q   <= head.data;
                            wr_strb_q  <= head.strb;
                        end else begin
                            state_q    <= RD_ACT;
                            rd_addr_q  <= head.addr;
                            rd_len_q   <= head.len;
                            rd_burst_q <= head.burst;
                            xor_q      <= '0;
                            beat_q     <= '0;
                        end
                    end
                end
                WR_ACT: begin
                    if (b_done || wd_hit) begin
                        state_q <= RESP;
                        wr_q    <= 1'b0;
                        done_q  <= 1'b1;
                        resp_q  <= b_done ? bresp : 2'b11;
                    end
                end
                RD_ACT: begin
                    if (r_beat) begin
                        xor_q  <= xor_q ^ rdata;
                        beat_q <= beat_q + {8'd0, ~&beat_q};
                    end
                    // beat_q counts earlier beats, so this final beat is number beat_q+1; a match needs beat_q == len.
                    if (r_beat && r_last) begin
                        state_q <= RESP;
                        done_q  <= 1'b1;
                        resp_q  <= (beat_q != {1'b0, rd_len_q}) ? 2'b10 : rresp;
                    end else if (wd_hit) begin
                        state_q <= RESP;
                        done_q  <= 1'b1;
                        resp_q  <= 2'b11;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (resp_q != 2'b00 && err_q != 8'hFF) err_q <= err_q + 8'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wr            = wr_q;
    assign wr_addr       = wr_addr_q;
    assign wr_burst_len  = wr_len_q;
    assign wr_burst_type = wr_burst_q;
    assign wr_din        = wr_din_q;
    assign wr_strbin     = wr_strb_q;
    assign rd_addr       = rd_addr_q;
    assign rd_burst_len  = rd_len_q;
    assign rd_burst_type = rd_burst_q;
    assign busy          = busy_q;
    assign cmd_done      = done_q;
    assign done_resp     = resp_q;
    assign rd_xor        = xor_q;
    assign err_cnt       = err_q;
endmodule

// File: tb/tb_axi_cmd_sequencer.sv
// tb_axi_cmd_sequencer: directed and random stimulus for axi_cmd_sequencer against a queue-based reference model.
module tb_axi_cmd_sequencer;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
`ifdef AXI_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0, resetn = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_wr;
    logic [31:0] cmd_addr, cmd_data;
    logic [7:0]  cmd_len;
    logic [1:0]  cmd_burst;
    logic [3:0]  cmd_strb;
    logic        wr;
    logic [31:0] wr_addr, wr_din, rd_addr;
    logic [7:0]  wr_burst_len, rd_burst_len;
    logic [1:0]  wr_burst_type, rd_burst_type;
    logic [3:0]  wr_strbin;
    logic        b_done, r_beat, r_last;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        busy, cmd_done;
    logic [1:0]  done_resp;
    logic [31:0] rd_xor;
    logic [7:0]  err_cnt;

    axi_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_burst(cmd_burst), .cmd_data(cmd_data), .cmd_strb(cmd_strb),
        .wr(wr), .wr_addr(wr_addr), .wr_burst_len(wr_burst_len), .wr_burst_type(wr_burst_type),
        .wr_din(wr_din), .wr_strbin(wr_strbin),
        .rd_addr(rd_addr), .rd_burst_len(rd_burst_len), .rd_burst_type(rd_burst_type),
        .b_done(b_done), .bresp(bresp), .r_beat(r_beat), .r_last(r_last), .rdata(rdata), .rresp(rresp),
        .busy(busy), .cmd_done(cmd_done), .done_resp(done_resp), .rd_xor(rd_xor), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        w;
        bit [31:0] addr;
        bit [7:0]  len;
        bit [1:0]  burst;
        bit [31:0] data;
        bit [3:0]  strb;
    } cmd_s;

    // Reference model: a command queue plus the phase of the command in flight
    // (0 none, 1 write outstanding, 2 read outstanding, 3 completion-pulse cycle).
    cmd_s      mq[$];
    cmd_s      cur, lw, lr, nc;
    int        ph, sync_n, beats, act_n;
    bit        can_pop, push_ok;
    bit [31:0] mxor;
    bit [1:0]  mresp;
    bit [7:0]  merr;

    int        checks = 0, errors = 0;
    int        done_cnt = 0, wr_cycles = 0;
    logic      wr_prev = 1'b0;
    bit [31:0] order[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        ph = 0; sync_n = 0; beats = 0; act_n = 0;
        mxor = '0; mresp = '0; merr = '0;
        lw = '{default: 0};
        lr = '{default: 0};
    endtask

    // Compare on the falling edge, then advance the model with the inputs the DUT samples next.
    initial forever begin
        @(negedge clk);
        if (!resetn) model_reset();
        chk("cmd_ready", cmd_ready, mq.size() < DEPTH);
        chk("busy", busy, ph != 0);
        chk("wr", wr, ph == 1);
        chk("cmd_done", cmd_done, ph == 3);
        chk("done_resp", done_resp, mresp);
        chk("rd_xor", rd_xor, mxor);
        chk("err_cnt", err_cnt, merr);
        chk("wr_addr", wr_addr, lw.addr);
        chk("wr_burst_len", wr_burst_len, lw.len);
        chk("wr_burst_type", wr_burst_type, lw.burst);
        chk("wr_din", wr_din, lw.data);
        chk("wr_strbin", wr_strbin, lw.strb);
        chk("rd_addr", rd_addr, lr.addr);
        chk("rd_burst_len", rd_burst_len, lr.len);
        chk("rd_burst_type", rd_burst_type, lr.burst);
        if (resetn) begin
            done_cnt  += cmd_done;
            wr_cycles += wr;
            if (wr && !wr_prev) order.push_back(wr_addr);
            wr_prev = wr;
            can_pop = sync_n >= 2;
            push_ok = cmd_valid && mq.size() < DEPTH;
            nc      = '{cmd_wr, cmd_addr, cmd_len, cmd_burst, cmd_data, cmd_strb};
            sync_n  = (sync_n < 2) ? sync_n + 1 : 2;
            case (ph)
                0: if (can_pop && mq.size() > 0) begin
                    cur   = mq.pop_front();
                    act_n = 0;
                    if (cur.w) begin ph = 1; lw = cur; end
                    else begin ph = 2; lr = cur; mxor = 0; beats = 0; end
                end
                1: begin
                    act_n++;
                    if (b_done) begin ph = 3; mresp = bresp; end
                    else if (TO_EN && act_n == TIMEOUT + 1) begin ph = 3; mresp = 2'b11; end
                end
                2: begin
                    act_n++;
                    if (r_beat) begin mxor ^= rdata; beats++; end
                    if (r_beat && r_last) begin ph = 3; mresp = (beats != cur.len + 1) ? 2'b10 : rresp; end
                    else if (TO_EN && act_n == TIMEOUT + 1) begin ph = 3; mresp = 2'b11; end
                end
                default: begin
                    ph = 0;
                    if (mresp != 0 && merr != 8'hFF) merr++;
                end
            endcase
            if (push_ok) mq.push_back(nc);
        end else wr_prev = 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cmd_valid = 0; cmd_wr = 0; cmd_addr = 0; cmd_len = 0; cmd_burst = 0; cmd_data = 0; cmd_strb = 0;
        b_done = 0; bresp = 0; r_beat = 0; r_last = 0; rdata = 0; rresp = 0;
    endtask

    task automatic push(bit w, bit [31:0] a, bit [7:0] l, bit [1:0] b, bit [31:0] d, bit [3:0] s);
        bit ok = 0;
        cmd_wr = w; cmd_addr = a; cmd_len = l; cmd_burst = b; cmd_data = d; cmd_strb = s;
        cmd_valid = 1;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = cmd_ready;
            tick();
        end
        cmd_valid = 0;
        chk("push_accepted", ok, 1);
    endtask

    task automatic wait_wr();
        for (int i = 0; i < 20 && !wr; i++) tick();
        chk("wr_entry", wr, 1);
    endtask

    task automatic wait_busy();
        for (int i = 0; i < 20 && !busy; i++) tick();
        chk("busy_entry", busy, 1);
    endtask

    int d0, w0, n;

    initial begin
        idle_inputs();
        repeat (3) tick();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_err_cnt", err_cnt, 0);
        resetn = 1;
        repeat (3) tick();

        // Write held for 20 cycles, completed with OKAY.
        d0 = done_cnt; w0 = wr_cycles;
        push(1, 32'h1, 8'd4, 2'b01, 32'h5, 4'hF);
        wait_wr();
        chk("t1_wr_addr", wr_addr, 32'h1);
        chk("t1_wr_din", wr_din, 32'h5);
        chk("t1_wr_len", wr_burst_len, 8'd4);
        repeat (19) tick();
        b_done = 1; bresp = 2'b00;
        tick();
        b_done = 0;
        repeat (3) tick();
        chk("t1_wr_cycles", wr_cycles - w0, 20);
        chk("t1_done_pulses", done_cnt - d0, 1);
        chk("t1_done_resp", done_resp, 2'b00);
        chk("t1_err_cnt", err_cnt, 0);

        // Five-beat read, XOR of one-hot data.
        d0 = done_cnt;
        push(0, 32'h1, 8'd4, 2'b01, 0, 0);
        wait_busy();
        for (int i = 0; i < 5; i++) begin
            r_beat = 1; rdata = 32'h1 << i; r_last = (i == 4); rresp = 0;
            tick();
        end
        r_beat = 0; r_last = 0;
        repeat (3) tick();
        chk("t2_rd_xor", rd_xor, 32'h1F);
        chk("t2_done_resp", done_resp, 2'b00);
        chk("t2_done_pulses", done_cnt - d0, 1);

        // Early r_last on beat 3 of a 5-beat read.
        push(0, 32'h40, 8'd4, 2'b01, 0, 0);
        wait_busy();
        for (int i = 0; i < 3; i++) begin
            r_beat = 1; rdata = 32'h10 + i; r_last = (i == 2);
            tick();
        end
        r_beat = 0; r_last = 0;
        repeat (3) tick();
        chk("t3_done_resp", done_resp, 2'b10);
        chk("t3_err_cnt", err_cnt, 1);

        // Fill the FIFO behind an active write, then drain in order.
        d0 = done_cnt;
        push(1, 32'h200, 8'd0, 2'b01, 32'hA, 4'h3);
        wait_wr();
        for (int i = 0; i < 4; i++) push(1, 32'h100 + i, 8'd1, 2'b01, i, 4'hF);
        chk("t4_full_ready", cmd_ready, 0);
        order.delete();
        b_done = 1; bresp = 0;
        push(1, 32'h104, 8'd1, 2'b01, 4, 4'hF);
        for (int i = 0; i < 100 && done_cnt - d0 < 6; i++) tick();
        b_done = 0;
        repeat (2) tick();
        chk("t4_done_pulses", done_cnt - d0, 6);
        chk("t4_order_size", order.size(), 5);
        for (int i = 0; i < 5; i++) chk("t4_order", (i < order.size()) ? order[i] : 32'hDEAD, 32'h100 + i);
        chk("t4_ready_after", cmd_ready, 1);

        // Reset mid-read with a second command queued.
        push(0, 32'h300, 8'd7, 2'b01, 0, 0);
        wait_busy();
        push(1, 32'h400, 8'd0, 2'b01, 1, 4'h1);
        r_beat = 1; rdata = 32'h77; r_last = 0;
        tick();
        r_beat = 0;
        d0 = done_cnt;
        resetn = 0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_wr", wr, 0);
        chk("t5_cmd_ready", cmd_ready, 1);
        chk("t5_cmd_done", cmd_done, 0);
        chk("t5_rd_xor", rd_xor, 0);
        repeat (2) tick();
        resetn = 1;
        repeat (10) tick();
        chk("t5_no_done", done_cnt - d0, 0);
        chk("t5_fifo_empty", busy, 0);

        // Write that never gets b_done.
        d0 = done_cnt;
        push(1, 32'h500, 8'd3, 2'b01, 32'h9, 4'hF);
        wait_wr();
`ifdef AXI_SEQ_TIMEOUT_EN
        n = 0;
        for (int i = 0; i < 40 && !cmd_done; i++) begin tick(); n++; end
        chk("t6_timeout_latency", n, 17);
        chk("t6_done_resp", done_resp, 2'b11);
        repeat (2) tick();
`else
        repeat (40) tick();
        chk("t6_still_busy", busy, 1);
        chk("t6_still_wr", wr, 1);
        chk("t6_no_done", done_cnt - d0, 0);
        resetn = 0;
        repeat (2) tick();
        resetn = 1;
        repeat (3) tick();
`endif

        // Random traffic, including stray completions outside active states.
        for (int i = 0; i < 3000; i++) begin
            cmd_valid = $urandom_range(0, 99) < 30;
            cmd_wr    = 1'($urandom);
            cmd_addr  = $urandom;
            cmd_len   = 8'($urandom_range(0, 3));
            cmd_burst = 2'($urandom);
            cmd_data  = $urandom;
            cmd_strb  = 4'($urandom);
            b_done    = $urandom_range(0, 99) < 10;
            bresp     = 2'($urandom);
            r_beat    = $urandom_range(0, 99) < 50;
            r_last    = $urandom_range(0, 99) < 25;
            rdata     = $urandom;
            rresp     = 2'($urandom);
            if (i == 1500) resetn = 0;
            if (i == 1503) resetn = 1;
            tick();
        end
        idle_inputs();
        repeat (5) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
